// File: rtl/fifo_reader_pkg.sv
// Shared encodings and default sizes for the packet FIFO reader.
// The FSM, output register and bench all import this package.
package fifo_reader_pkg;

    localparam int B_DEF = 8;
    localparam int W_DEF = 4;
    localparam int CNT_W = 16;

    typedef enum logic {
        S_HDR = 1'b0,
        S_PAY = 1'b1
    } state_t;

endpackage

// File: rtl/fifo.sv
// Circular FIFO with first-word fall-through: r_data shows the head word whenever empty=0.
// Writes while full are dropped; pops while empty are ignored; one write and one pop per cycle.
module fifo #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [B-1:0] w_data,
    output logic         empty,
    output logic         full,
    output logic [B-1:0] r_data
);

    logic [B-1:0] r_mem [2**W];
    logic [W-1:0] r_wptr;
    logic [W-1:0] r_rptr;
    logic         r_full;
    logic         r_empty;
    logic         w_wr_en;
    logic         w_rd_en;

    assign w_wr_en = wr && !r_full;
    assign w_rd_en = rd && !r_empty;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            case ({w_wr_en, w_rd_en})
                2'b01: begin
                    r_rptr  <= r_rptr + W'(1);
                    r_full  <= 1'b0;
                    r_empty <= (r_rptr + W'(1)) == r_wptr;
                end
                2'b10: begin
                    r_wptr  <= r_wptr + W'(1);
                    r_empty <= 1'b0;
                    r_full  <= (r_wptr + W'(1)) == r_rptr;
                end
                2'b11: begin
                    r_wptr <= r_wptr + W'(1);
                    r_rptr <= r_rptr + W'(1);
                end
                default: ;
            endcase
        end
    end

    assign empty  = r_empty;
    assign full   = r_full;
    assign r_data = r_mem[r_rptr];

endmodule

// File: rtl/fifo_reader_outreg.sv
// Single-entry output register: a load wins over an accept, so a word can be replaced in the
// cycle it is taken (full rate); with out_ready low the held word and its last flag stay put.
module fifo_reader_outreg
    import fifo_reader_pkg::*;
#(
    parameter int B = B_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [B-1:0] i_data,
    input  logic         i_last,
    input  logic         i_ready,
    output logic [B-1:0] o_data,
    output logic         o_valid,
    output logic         o_last
);

    logic [B-1:0] r_data;
    logic         r_valid;
    logic         r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_last  = r_last;

endmodule

// File: rtl/fifo_reader.sv
// Splits a length-prefixed word stream into payload packets; payload reaches out_data one cycle after its pop.
// Pops stall while a held word is refused by out_ready; FIFO_READER_CNT_EN adds the pkt_count output.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int B = B_DEF,
    parameter int W = W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             empty,
    input  logic [B-1:0]     r_data,
    output logic             rd,
    output logic [B-1:0]     out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
`ifdef FIFO_READER_CNT_EN
    output logic [CNT_W-1:0] pkt_count,
`endif
    output logic             zero_len
);

    if (B < 1 || W < 1) begin : g_bad_param
        $error("fifo_reader: B and W must be at least 1");
    end

    state_t       r_state;
    logic [B-1:0] r_remaining;
    logic         r_zero_len;
    logic         w_hdr_pop;
    logic         w_pay_pop;
    logic         w_is_last;

    // Gated by reset so no word leaves the FIFO while the reader is being cleared.
    assign w_hdr_pop = !reset && (r_state == S_HDR) && !empty;
    assign w_pay_pop = !reset && (r_state == S_PAY) && !empty && (!out_valid || out_ready);
    assign w_is_last = (r_remaining == B'(1));
    assign rd        = w_hdr_pop || w_pay_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_HDR;
            r_remaining <= '0;
            r_zero_len  <= 1'b0;
        end else begin
            r_zero_len <= 1'b0;
            case (r_state)
                S_HDR: begin
                    if (w_hdr_pop) begin
                        r_remaining <= r_data;
                        if (r_data == '0) begin
                            r_zero_len <= 1'b1;
                        end else begin
                            r_state <= S_PAY;
                        end
                    end
                end
                S_PAY: begin
                    if (w_pay_pop) begin
                        r_remaining <= r_remaining - B'(1);
                        if (w_is_last) begin
                            r_state <= S_HDR;
                        end
                    end
                end
                default: r_state <= S_HDR;
            endcase
        end
    end

    assign zero_len = r_zero_len;

    fifo_reader_outreg #(.B(B)) u_outreg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_pay_pop),
        .i_data  (r_data),
        .i_last  (w_is_last),
        .i_ready (out_ready),
        .o_data  (out_data),
        .o_valid (out_valid),
        .o_last  (out_last)
    );

`ifdef FIFO_READER_CNT_EN
    logic [CNT_W-1:0] r_pkt_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_count <= '0;
        end else if (out_valid && out_ready && out_last) begin
            r_pkt_count <= r_pkt_count + CNT_W'(1);
        end
    end

    assign pkt_count = r_pkt_count;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Circular FIFO feeding fifo_reader; a packet-level model fills an expected queue that a monitor drains.
module tb_fifo_reader;
    import fifo_reader_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr;
    logic [7:0] w_data;
    logic       empty;
    logic       full;
    logic [7:0] r_data;
    logic       rd;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       zero_len;
`ifdef FIFO_READER_CNT_EN
    logic [15:0] pkt_count;
`endif

    always #5 clk = ~clk;

    fifo #(.B(8), .W(4)) u_fifo (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .w_data(w_data),
        .empty(empty), .full(full), .r_data(r_data)
    );

    fifo_reader #(.B(8), .W(4)) dut (
        .clk(clk), .reset(reset), .empty(empty), .r_data(r_data), .rd(rd),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready),
`ifdef FIFO_READER_CNT_EN
        .pkt_count(pkt_count),
`endif
        .zero_len(zero_len)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 1;     // 0 random, 1 always ready, 2 never ready
    int rd_bad = 0;
    int zero_seen = 0;
    int zero_exp = 0;
    int pkt_exp = 0;
    int model_rem = 0;
    logic [8:0] exp_q[$];   // {last, data}
    int xfer_cyc[$];

    // Packet-level model: headers set the count, following words become expected outputs.
    task automatic model_feed(input logic [7:0] w);
        if (model_rem == 0) begin
            if (w == 8'd0) zero_exp++;
            else model_rem = int'(w);
        end else begin
            exp_q.push_back({model_rem == 1, w});
            if (model_rem == 1) pkt_exp = (pkt_exp + 1) % 65536;
            model_rem--;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        int n = 0;
        while (full && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (full) chk("push_timeout", 32'(full), 32'd0);
        wr = 1'b1; w_data = w; model_feed(w);
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (!(exp_q.size() == 0 && !out_valid && empty) && n < 2000) begin
            @(negedge clk); n++;
        end
        chk("drain_done", 32'(exp_q.size() == 0 && !out_valid && empty), 32'd1);
        @(posedge clk); #1;
    endtask

    initial forever begin
        @(posedge clk); cyc++;
        #1;
        case (ready_mode)
            0:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor: scoreboard compare on every transfer, hold stability while stalled.
    logic       hold_v = 1'b0;
    logic [7:0] hold_d;
    logic       hold_l;
    initial forever begin
        @(negedge clk);
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (rd && empty) rd_bad++;
            if (zero_len) zero_seen++;
            if (hold_v && out_valid) begin
                chk("hold_data", 32'(out_data), 32'(hold_d));
                chk("hold_last", 32'(out_last), 32'(hold_l));
            end
            if (out_valid && out_ready) begin
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(out_data), 32'h1ff);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e[7:0]));
                    chk("out_last", 32'(out_last), 32'(e[8]));
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int zs;
        reset = 1'b1; wr = 1'b0; w_data = 8'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_zero_len", 32'(zero_len), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        @(posedge clk); #1; reset = 1'b0;

        // Three-word packet at full rate
        ready_mode = 1;
        xfer_cyc.delete();
        push_word(8'd3); push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
        drain();
        chk("t1_xfers", 32'(xfer_cyc.size()), 32'd3);
        if (xfer_cyc.size() == 3) begin
            chk("t1_back2back_a", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd1);
            chk("t1_back2back_b", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd1);
        end

        // Zero-length header then a one-word packet
        zs = zero_seen;
        push_word(8'd0); push_word(8'd1); push_word(8'h55);
        drain();
        chk("t2_zero_pulses", 32'(zero_seen - zs), 32'd1);

        // Stall with out_ready low for five cycles
        ready_mode = 2;
        push_word(8'd2); push_word(8'h11); push_word(8'h22);
        begin
            int n = 0;
            while (!out_valid && n < 100) begin @(negedge clk); n++; end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_held_valid", 32'(out_valid), 32'd1);
            chk("t3_held_data", 32'(out_data), 32'h11);
            chk("t3_no_pop", 32'(rd), 32'd0);
        end
        ready_mode = 1;
        drain();

        // Back-to-back single-word packets
        push_word(8'd1); push_word(8'h7E); push_word(8'd1); push_word(8'h7F);
        drain();
`ifdef FIFO_READER_CNT_EN
        chk("pkt_count_mid", 32'(pkt_count), 32'(pkt_exp));
`endif

        // Reset in the middle of a packet
        push_word(8'd4); push_word(8'd1); push_word(8'd2);
        drain();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_rd", 32'(rd), 32'd0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        model_rem = 0; exp_q.delete(); pkt_exp = 0;
        @(posedge clk); #1;
        push_word(8'd1); push_word(8'h99);
        drain();

        // Randomized packets with random backpressure and write gaps
        ready_mode = 0;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(0, 6);
            push_word(8'(len));
            for (int k = 0; k < len; k++) begin
                push_word(8'($urandom_range(0, 255)));
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            end
        end
        ready_mode = 1;
        drain();

        chk("rd_while_empty", 32'(rd_bad), 32'd0);
        chk("zero_len_total", 32'(zero_seen), 32'(zero_exp));
        chk("leftover_expected", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_READER_CNT_EN
        chk("pkt_count_end", 32'(pkt_count), 32'(pkt_exp));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter B, default 8: data word width; also the width of the packet length header.
REQ-002 Parameter W, default 4: address width of the upstream circular FIFO; informational only, no logic depends on it.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 empty  input  1  upstream FIFO empty flag.
REQ-006 r_data  input  B  upstream FIFO head word; first-word fall-through, valid whenever empty=0.
REQ-007 rd  output  1  combinational pop strobe to the FIFO; one word popped per cycle with rd=1.
REQ-008 out_data  output  B  payload word, registered.
REQ-009 out_valid  output  1  out_data valid, registered.
REQ-010 out_last  output  1  final payload word of a packet; qualified by out_valid.
REQ-011 out_ready  input  1  downstream accept; a transfer occurs when out_valid=1 and out_ready=1.
REQ-012 zero_len  output  1  registered one-cycle pulse on a length-0 header.

Function
REQ-013 Stream format: a header word L (unsigned, B bits), then L payload words; L=0 means a header with no payload.
REQ-014 FSM states: S_HDR (await header) and S_PAY (stream payload).
REQ-015 In S_HDR with empty=0:
- rd=1; remaining <= r_data.
- r_data==0: zero_len pulses next cycle; state stays S_HDR.
- Otherwise: next state S_PAY.
REQ-016 In S_PAY, pop condition = empty=0 and (out_valid=0 or out_ready=1); rd equals the pop condition.
REQ-017 On a payload pop, next cycle:
- out_data=r_data, out_valid=1.
- out_last=(remaining==1).
- remaining decrements by 1.
- if remaining==1: state returns to S_HDR.
REQ-018 Transfer with no pop in the same cycle: out_valid clears next cycle.
REQ-019 Transfer and pop in the same cycle: out_valid stays 1 and out_data is replaced; full throughput, one word per cycle.
REQ-020 out_valid=1 and out_ready=0: out_data and out_last hold stable; no payload pop.
REQ-021 Latency: payload word at FIFO head in cycle n with pop condition true appears on out_data in cycle n+1.
REQ-022 A header pop in S_HDR may coincide with a pending or accepted last word; the header pop never alters out_data, out_valid or out_last.
REQ-023 empty=1 in any state: rd=0 and no state change, except the out_valid clear of REQ-018.
REQ-024 rd is never asserted when empty=1.

Reset
REQ-025 While reset=1: state=S_HDR, remaining=0, out_valid=0, out_last=0, out_data=0, zero_len=0, rd=0.
REQ-026 Reset mid-packet discards the partial packet; on release the next FIFO word is treated as a header.

Configuration
REQ-027 Macro FIFO_READER_CNT_EN defined: adds output pkt_count, 16 bits; reset value 0; increments by 1 on each transfer with out_last=1; wraps from 65535 to 0.
REQ-028 Macro FIFO_READER_CNT_EN undefined: pkt_count port and its logic are absent; all other behaviour is identical.

Structure
REQ-029 Shared package fifo_reader_pkg holds the state encodings (S_HDR=0, S_PAY=1), the defaults for B and W, and the counter width constant 16.
REQ-030 There is one sub-module, fifo_reader_outreg: the out_data/out_valid/out_last register with load/accept control. The FSM and counter live in fifo_reader.

Verification
REQ-031 The bench instantiates the existing circular FIFO (B=8, W=4) feeding fifo_reader and covers the directed scenarios below.
REQ-032 Write 3,0xA1,0xA2,0xA3 with out_ready=1 -> out_data 0xA1,0xA2,0xA3 on consecutive cycles; out_last=1 only with 0xA3.
REQ-033 Write 0 then 1,0x55 -> zero_len pulses exactly once; one output word 0x55 with out_last=1.
REQ-034 Write 2,0x11,0x22 with out_ready=0 for 5 cycles, then 1 -> 0x11 held stable for 5 cycles with no pop; then 0x11 and 0x22 delivered in order.
REQ-035 Write 1,0x7E,1,0x7F back-to-back with out_ready=1 -> both words delivered, each with out_last=1; no rd while empty=1.
REQ-036 Write 4,1,2 then assert reset for 1 cycle, then write 1,0x99 -> post-reset output is only 0x99 with out_last=1.
REQ-037 With FIFO_READER_CNT_EN defined, run the REQ-032 and REQ-035 streams -> pkt_count reaches 3.
